// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcode/funct constants,
// ALU function codes, FSM state encoding and the decoded control bundle.
package ctrl_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLLV = 6'b000100;

   // ALU function codes, shared with the ALU
   typedef enum logic [2:0] {
      ALU_AND = 3'd0,
      ALU_OR  = 3'd1,
      ALU_XOR = 3'd2,
      ALU_NOR = 3'd3,
      ALU_ADD = 3'd4,
      ALU_SUB = 3'd5,
      ALU_SLT = 3'd6,
      ALU_SLL = 3'd7
   } alu_op_t;

   // Controller states
   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_LOAD_IR = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_MEM     = 3'd4,
      ST_WB      = 3'd5,
      ST_HALT    = 3'd6
   } state_t;

   // Decoded control bundle for one instruction
   typedef struct packed {
      alu_op_t alu_op;
      logic    alu_src_b;
      logic    ext_sel;
      logic    mem_to_reg;
      logic    is_lw;
      logic    is_sw;
      logic    is_beq;
      logic    is_wb;
      logic    illegal;
   } ctrl_t;

   // Byte displacement of a branch: sign-extended word offset times four
   function automatic logic [31:0] branch_disp(input logic [15:0] off);
      return {{14{off[15]}}, off, 2'b00};
   endfunction

endpackage

// File: rtl/inst_decoder.sv
// Purely combinational instruction decoder: opcode/funct to control bundle.
// Unsupported encodings yield an all-zero bundle with only the illegal flag set.
module inst_decoder
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_t      ctrl
);

   // Translate the opcode (and funct for R-type) into control fields
   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.is_wb = 1'b1;
            case (funct)
               FN_AND:  ctrl.alu_op = ALU_AND;
               FN_OR:   ctrl.alu_op = ALU_OR;
               FN_XOR:  ctrl.alu_op = ALU_XOR;
               FN_NOR:  ctrl.alu_op = ALU_NOR;
               FN_ADD:  ctrl.alu_op = ALU_ADD;
               FN_SUB:  ctrl.alu_op = ALU_SUB;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               FN_SLLV: ctrl.alu_op = ALU_SLL;
               default: begin
                  ctrl         = '0;
                  ctrl.illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.alu_src_b = 1'b1;
            ctrl.ext_sel   = 1'b1;
            ctrl.is_wb     = 1'b1;
         end
         OP_ANDI: begin
            ctrl.alu_op    = ALU_AND;
            ctrl.alu_src_b = 1'b1;
            ctrl.is_wb     = 1'b1;
         end
         OP_ORI: begin
            ctrl.alu_op    = ALU_OR;
            ctrl.alu_src_b = 1'b1;
            ctrl.is_wb     = 1'b1;
         end
         OP_XORI: begin
            ctrl.alu_op    = ALU_XOR;
            ctrl.alu_src_b = 1'b1;
            ctrl.is_wb     = 1'b1;
         end
         OP_LW: begin
            ctrl.alu_op     = ALU_ADD;
            ctrl.alu_src_b  = 1'b1;
            ctrl.ext_sel    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.is_lw      = 1'b1;
            ctrl.is_wb      = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.alu_src_b = 1'b1;
            ctrl.ext_sel   = 1'b1;
            ctrl.is_sw     = 1'b1;
         end
         OP_BEQ: begin
            // Compare rs against rt, so operand B stays the register
            ctrl.alu_op  = ALU_SUB;
            ctrl.ext_sel = 1'b1;
            ctrl.is_beq  = 1'b1;
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/control unit. Holds PC and IR, sequences each
// instruction through FETCH..WB and drives the datapath control lines.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          ROM_AW   = 6
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [31:0]       Inst_Data,
   input  logic              ZF,
   output logic [ROM_AW-1:0] Inst_Addr,
   output logic [31:0]       PC,
   output logic [31:0]       IR,
   output logic [4:0]        RS,
   output logic [4:0]        RT,
   output logic [4:0]        W_Addr,
   output logic [15:0]       offset,
   output logic              Ext_Sel,
   output logic              ALU_SrcB,
   output logic [2:0]        ALU_OP,
   output logic              Write_Reg,
   output logic              Mem_Write,
   output logic              Mem_to_Reg,
   output logic              Illegal,
   output logic [2:0]        State
);

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] ir_r;
   ctrl_t       ctl_r;
   ctrl_t       dec_s;
   logic        illegal_r;
   logic        write_reg_r;
   logic        mem_write_r;

   // The decoder looks at the ROM word being latched so that the control
   // bundle can be registered alongside IR and is stable from DECODE on.
   inst_decoder u_dec (
      .opcode (Inst_Data[31:26]),
      .funct  (Inst_Data[5:0]),
      .ctrl   (dec_s)
   );

   // Sequencer: state, PC, IR, held control bundle and one-cycle strobes
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_r     <= ST_FETCH;
         pc_r        <= PC_RESET;
         ir_r        <= 32'h0000_0000;
         ctl_r       <= '0;
         illegal_r   <= 1'b0;
         write_reg_r <= 1'b0;
         mem_write_r <= 1'b0;
      end else begin
         write_reg_r <= 1'b0;
         mem_write_r <= 1'b0;
         case (state_r)
            ST_FETCH: begin
               state_r <= ST_LOAD_IR;
            end
            ST_LOAD_IR: begin
               ir_r    <= Inst_Data;
               pc_r    <= pc_r + 32'd4;
               ctl_r   <= dec_s;
               state_r <= ST_DECODE;
            end
            ST_DECODE: begin
               if (ctl_r.illegal) begin
                  illegal_r <= 1'b1;
                  ctl_r     <= '0;
                  state_r   <= ST_HALT;
               end else begin
                  state_r <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (ctl_r.is_beq) begin
                  // Target is relative to the already-incremented PC
                  if (ZF) begin
                     pc_r <= pc_r + branch_disp(ir_r[15:0]);
                  end else begin
                     pc_r <= pc_r;
                  end
                  ctl_r   <= '0;
                  state_r <= ST_FETCH;
               end else if (ctl_r.is_lw || ctl_r.is_sw) begin
                  mem_write_r <= ctl_r.is_sw;
                  state_r     <= ST_MEM;
               end else if (ctl_r.is_wb) begin
                  write_reg_r <= 1'b1;
                  state_r     <= ST_WB;
               end else begin
                  ctl_r   <= '0;
                  state_r <= ST_FETCH;
               end
            end
            ST_MEM: begin
               if (ctl_r.is_lw) begin
                  write_reg_r <= 1'b1;
                  state_r     <= ST_WB;
               end else begin
                  ctl_r   <= '0;
                  state_r <= ST_FETCH;
               end
            end
            ST_WB: begin
               ctl_r   <= '0;
               state_r <= ST_FETCH;
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               ctl_r   <= '0;
               state_r <= ST_FETCH;
            end
         endcase
      end
   end

   assign Inst_Addr  = pc_r[ROM_AW+1:2];
   assign PC         = pc_r;
   assign IR         = ir_r;
   assign RS         = ir_r[25:21];
   assign RT         = ir_r[20:16];
   assign offset     = ir_r[15:0];
   assign W_Addr     = (ir_r[31:26] == OP_RTYPE) ? ir_r[15:11] : ir_r[20:16];
   assign Ext_Sel    = ctl_r.ext_sel;
   assign ALU_SrcB   = ctl_r.alu_src_b;
   assign ALU_OP     = ctl_r.alu_op;
   assign Mem_to_Reg = ctl_r.mem_to_reg;
   assign Illegal    = illegal_r;
   assign State      = state_r;
   // Reset cuts the strobes immediately so an interrupted instruction never writes
   assign Write_Reg  = write_reg_r & ~Reset;
   assign Mem_Write  = mem_write_r & ~Reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed programs from the test
// plan plus a random program, checked against an instruction-level model.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Inst_Data = 32'h0;
   logic        ZF = 1'b0;
   logic [5:0]  Inst_Addr;
   logic [31:0] PC, IR;
   logic [4:0]  RS, RT, W_Addr;
   logic [15:0] offset;
   logic        Ext_Sel, ALU_SrcB, Write_Reg, Mem_Write, Mem_to_Reg, Illegal;
   logic [2:0]  ALU_OP, State;

   multicycle_ctrl dut (
      .clk(clk), .Reset(Reset), .Inst_Data(Inst_Data), .ZF(ZF),
      .Inst_Addr(Inst_Addr), .PC(PC), .IR(IR), .RS(RS), .RT(RT),
      .W_Addr(W_Addr), .offset(offset), .Ext_Sel(Ext_Sel),
      .ALU_SrcB(ALU_SrcB), .ALU_OP(ALU_OP), .Write_Reg(Write_Reg),
      .Mem_Write(Mem_Write), .Mem_to_Reg(Mem_to_Reg), .Illegal(Illegal),
      .State(State)
   );

   always #5 clk = ~clk;

   // Instruction tables: R-type ALU code is the index into r_fn
   logic [5:0]  r_fn   [8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2A, 6'h04};
   logic [5:0]  i_opc  [7] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04};
   logic [2:0]  i_alu  [7] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd5};
   logic        i_ext  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   int          i_kind [7] = '{0, 0, 0, 0, 1, 2, 3};
   // kind: 0 = ALU write-back, 1 = lw, 2 = sw, 3 = beq
   int          cpi    [4] = '{5, 6, 5, 4};

   logic [31:0] rom [64];
   logic [31:0] m_pc;
   logic [5:0]  addr_q;
   int          n_total = 0;
   int          n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic void classify(input logic [31:0] ins, output bit legal, output int kind,
                                    output logic [2:0] op, output logic srcb, output logic ext);
      legal = 1'b0; kind = 0; op = 3'd0; srcb = 1'b0; ext = 1'b0;
      if (ins[31:26] == 6'd0) begin
         for (int k = 0; k < 8; k++) begin
            if (ins[5:0] == r_fn[k]) begin
               legal = 1'b1; op = 3'(k);
            end
         end
      end else begin
         for (int k = 0; k < 7; k++) begin
            if (ins[31:26] == i_opc[k]) begin
               legal = 1'b1; kind = i_kind[k]; op = i_alu[k]; ext = i_ext[k];
               srcb = (i_kind[k] != 3);
            end
         end
      end
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      w = $urandom();
      k = $urandom_range(0, 10);
      if (k < 4) begin
         w[31:26] = 6'd0;
         w[5:0]   = r_fn[$urandom_range(0, 7)];
      end else begin
         w[31:26] = i_opc[$urandom_range(0, 6)];
         if (w[31:26] == 6'h04) w[15:0] = 16'($urandom_range(0, 16)) - 16'd8;
      end
      return w;
   endfunction

   task automatic do_reset();
      Reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_pc", PC, 32'h0);
      chk("rst_ir", IR, 32'h0);
      chk("rst_state", 32'(State), 32'(ST_FETCH));
      chk("rst_illegal", 32'(Illegal), 32'h0);
      chk("rst_strobes", 32'({Write_Reg, Mem_Write}), 32'h0);
      chk("rst_sels", 32'({ALU_OP, ALU_SrcB, Ext_Sel, Mem_to_Reg}), 32'h0);
      Reset = 1'b0;
      m_pc = 32'h0;
      addr_q = 6'd0;
   endtask

   // Run one instruction from FETCH; zf_sel 0/1 forces ZF in EXEC, 2 = random.
   // reset_at >= 0 raises Reset in that cycle and abandons the instruction.
   task automatic run_instr(input int zf_sel, input int reset_at);
      logic [31:0] ins;
      bit          legal;
      int          kind, n;
      logic [2:0]  op;
      logic        srcb, ext, zf_used, wb;
      logic [4:0]  wa;
      bit          aborted;
      ins = rom[m_pc[7:2]];
      classify(ins, legal, kind, op, srcb, ext);
      wa = (ins[31:26] == 6'd0) ? ins[15:11] : ins[20:16];
      n = legal ? cpi[kind] : 3;
      wb = legal && (kind <= 1);
      zf_used = 1'b0;
      aborted = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i < 2) begin
            chk("pc_early", PC, m_pc);
            chk("sel_early", 32'({ALU_OP, ALU_SrcB, Ext_Sel}), 32'h0);
            if (i == 0) chk("inst_addr", 32'(Inst_Addr), 32'(m_pc[7:2]));
         end else begin
            chk("pc_inc", PC, m_pc + 32'd4);
            chk("ir", IR, ins);
            chk("rs_rt", 32'({RS, RT}), 32'(ins[25:16]));
            chk("offset", 32'(offset), 32'(ins[15:0]));
            chk("w_addr", 32'(W_Addr), 32'(wa));
            if (legal) begin
               chk("alu_op", 32'(ALU_OP), 32'(op));
               chk("srcb_ext", 32'({ALU_SrcB, Ext_Sel}), 32'({srcb, ext}));
               chk("mem_to_reg", 32'(Mem_to_Reg), 32'(kind == 1));
            end
         end
         chk("write_reg", 32'(Write_Reg), 32'(wb && (i == n - 1)));
         chk("mem_write", 32'(Mem_Write), 32'(legal && kind == 2 && i == 4));
         chk("illegal_lo", 32'(Illegal), 32'h0);
         if (i == reset_at) begin
            Reset = 1'b1;
            #1;
            chk("wr_in_reset", 32'(Write_Reg), 32'h0);
            aborted = 1'b1;
            break;
         end
         Inst_Data = rom[addr_q];
         addr_q = Inst_Addr;
         ZF = (i == 3 && zf_sel < 2) ? zf_sel[0] : 1'($urandom_range(0, 1));
         if (i == 3) zf_used = ZF;
         @(posedge clk); #1;
      end
      if (!aborted) begin
         if (legal) begin
            m_pc = m_pc + 32'd4;
            if (kind == 3 && zf_used) m_pc = m_pc + {{14{ins[15]}}, ins[15:0], 2'b00};
         end else begin
            chk("halt_state", 32'(State), 32'(ST_HALT));
            chk("illegal_hi", 32'(Illegal), 32'h1);
            for (int c = 0; c < 20; c++) begin
               ZF = 1'($urandom_range(0, 1));
               Inst_Data = $urandom();
               @(posedge clk); #1;
               chk("halt_strobes", 32'({Write_Reg, Mem_Write}), 32'h0);
               chk("halt_pc", PC, m_pc + 32'd4);
               chk("halt_ir", IR, ins);
               chk("halt_sels", 32'({ALU_OP, ALU_SrcB, Ext_Sel}), 32'h0);
               chk("halt_sticky", 32'({Illegal, State}), 32'({1'b1, ST_HALT}));
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 64; a++) rom[a] = 32'hFC00_0000;
      m_pc = 32'h0;
      addr_q = 6'd0;

      // Directed program: addi, add, lw, sw, beq taken/not taken, illegal opcode
      rom[0] = 32'h2001_0005;
      rom[1] = 32'h0022_1820;
      rom[2] = 32'h8C04_0008;
      rom[3] = 32'hAC04_0008;
      rom[4] = 32'h1000_FFFF;
      rom[5] = 32'hFC00_0000;
      do_reset();
      for (int k = 0; k < 4; k++) run_instr(2, -1);
      run_instr(1, -1);
      chk("beq_taken_pc", PC, 32'h0000_0010);
      run_instr(0, -1);
      chk("beq_not_taken_pc", PC, 32'h0000_0014);
      run_instr(2, -1);
      do_reset();

      // Reset during the write-back cycle of an add
      rom[0] = 32'h0022_1820;
      run_instr(2, 4);
      @(posedge clk); #1;
      chk("rst_wb_state", 32'(State), 32'(ST_FETCH));
      chk("rst_wb_pc", PC, 32'h0);
      chk("rst_wb_wr", 32'(Write_Reg), 32'h0);
      do_reset();

      // PC wrap: branch back to 0xFFFFFFFC, then +4 returns to 0
      rom[0]  = 32'h1000_FFFE;
      rom[63] = 32'h2001_0005;
      run_instr(1, -1);
      chk("pc_to_top", PC, 32'hFFFF_FFFC);
      run_instr(2, -1);
      chk("pc_wrap", PC, 32'h0);
      do_reset();

      // Illegal R-type funct halts as well
      rom[0] = 32'h0022_1801;
      run_instr(2, -1);
      do_reset();

      // Random program with random ZF
      for (int a = 0; a < 64; a++) rom[a] = rand_instr();
      for (int k = 0; k < 250; k++) run_instr(2, -1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle fetch/decode/control unit that drives the register-file + ALU + data-RAM datapath. It holds the PC and fetches from a synchronous 64-word instruction ROM. It latches each instruction into IR and sequences one instruction at a time through FETCH..WB, producing RS/RT/W_Addr/offset, ALU_OP, Write_Reg and Mem_Write. It sits directly upstream of the datapath and consumes ZF back from the ALU for beq.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- ROM_AW, 6, instruction ROM word-address width; Inst_Addr = PC[ROM_AW+1:2]

Ports:
- clk  in  1  single clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Inst_Data  in  32  ROM douta; valid the cycle after Inst_Addr is presented
- ZF  in  1  ALU zero flag
- Inst_Addr  out  ROM_AW  ROM word address
- PC  out  32  current PC
- IR  out  32  latched instruction
- RS, RT, W_Addr  out  5 each  register addresses
- offset  out  16  IR[15:0]
- Ext_Sel  out  1  1 = sign-extend offset, 0 = zero-extend
- ALU_SrcB  out  1  1 = extended offset, 0 = register B
- ALU_OP  out  3  ALU function code (0 and … 7 sll)
- Write_Reg  out  1  register write strobe
- Mem_Write  out  1  data RAM write strobe
- Mem_to_Reg  out  1  1 = write-back data from RAM, 0 = ALU result
- Illegal  out  1  sticky: unsupported opcode/funct seen
- State  out  3  current state, debug

## Operation
- States: FETCH, LOAD_IR, DECODE, EXEC, MEM, WB, HALT.
- FETCH: present Inst_Addr = PC[7:2]. Goes to LOAD_IR.
- LOAD_IR: IR <= Inst_Data; PC <= PC+4. Goes to DECODE.
- DECODE: register addresses are stable for register-file read. Illegal opcode: set Illegal and go to HALT. Otherwise go to EXEC.
- EXEC: ALU_OP/ALU_SrcB/Ext_Sel asserted. Next state:
  - R-type and ALU-immediate: WB.
  - lw/sw: MEM.
  - beq: FETCH. If ZF, PC <= PC + (sign_ext(offset)<<2), relative to the already-incremented PC.
- MEM: sw asserts Mem_Write for this one cycle, then goes to FETCH. lw goes to WB.
- WB: Write_Reg=1 for this one cycle; Mem_to_Reg=1 for lw. Goes to FETCH.
- HALT: absorbing until Reset. All strobes 0; PC and IR frozen.
- RS=IR[25:21], RT=IR[20:16], offset=IR[15:0]. All three are combinational from IR.
- W_Addr: rd=IR[15:11] for R-type, rt for I-type.
- Decode, R-type (opcode 000000), funct → ALU_OP:
  - 100100 and → 0
  - 100101 or → 1
  - 100110 xor → 2
  - 100111 nor → 3
  - 100000 add → 4
  - 100010 sub → 5
  - 101010 slt → 6
  - 000100 sllv → 7 (rt << rs)
  - any other funct: illegal
- Decode, I-type (ALU_SrcB=1 except beq):
  - addi 001000 → 4, Ext_Sel=1
  - andi 001100 → 0, Ext_Sel=0
  - ori 001101 → 1, Ext_Sel=0
  - xori 001110 → 2, Ext_Sel=0
  - lw 100011 / sw 101011 → 4, Ext_Sel=1
  - beq 000100 → 5, ALU_SrcB=0
- Ext_Sel, ALU_SrcB and ALU_OP are held from DECODE through WB. They are 0 in FETCH, LOAD_IR and HALT.

## Timing
- Cycles per instruction: beq 4, R/ALU-imm 5, sw 5, lw 6.
- Reset values: PC=PC_RESET, IR=0, state=FETCH, Illegal=0. All strobes and select outputs are 0.
- Reset is sampled at the clock edge. While Reset=1, Write_Reg and Mem_Write are forced 0 combinationally, so reset mid-instruction never produces a partial write.
- After Reset deasserts, the first FETCH is the next cycle and IR is loaded 2 cycles later.
- Arithmetic:
  - PC arithmetic is modulo 2^32. PC 32'hFFFF_FFFC + 4 = 0.
  - Inst_Addr wraps modulo 64. PC=0x100 fetches ROM word 0.
  - Branch target = PC+4 + sign_ext(offset)<<2; a negative offset branches backward.
- ZF is sampled only in EXEC of beq. ZF in any other state is ignored.
- Write_Reg and Mem_Write are never high in the same cycle. Each is high for exactly one cycle per qualifying instruction.

## Structure
- Package ctrl_pkg holds:
  - opcode and funct constants;
  - ALU_OP codes (AND=0 … SLL=7), shared with the ALU;
  - state encoding (3-bit enum);
  - the control-bundle struct {ALU_OP, ALU_SrcB, Ext_Sel, Mem_to_Reg, is_lw, is_sw, is_beq, is_wb, illegal}.
- Sub-module inst_decoder: purely combinational, IR → control bundle. The FSM, PC and IR registers stay in multicycle_ctrl.

## Test plan
- Reset then ROM[0]=0x2001_0005 (addi $1,$0,5) → on the 5th cycle Write_Reg=1, W_Addr=1, ALU_OP=4, Ext_Sel=1, ALU_SrcB=1; PC=4.
- R-type add $3,$1,$2 (0x0022_1820) → RS=1, RT=2, W_Addr=3, ALU_OP=4, ALU_SrcB=0; Write_Reg pulse exactly 1 cycle.
- lw $4,8($0) (0x8C04_0008) → MEM then WB with Mem_to_Reg=1, Write_Reg=1, 6 cycles total. sw (0xAC04_0008) → Mem_Write=1 for 1 cycle, Write_Reg never 1.
- beq at PC=0x10 with offset 0xFFFF and ZF=1 → next fetch PC=0x10. With ZF=0 → PC=0x14. 4 cycles each.
- Opcode 0x3F → Illegal=1 and State=HALT. Strobes stay 0 for 20 cycles. Reset → PC=0, Illegal=0.
- Assert Reset during WB of an add → Write_Reg=0 that cycle, next state FETCH, PC=PC_RESET.
